// File: rtl/node_tx_queue.sv
// node_tx_queue: per-node transmit FIFO feeding router_core, head retired on each rising Core_Load_Ack.
// Optional NODE_TXQ_SELF_FILTER_EN drops packets addressed to this router instead of queueing them.
module node_tx_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 24,
  localparam int PKT_W = ADDR_W + 1 + DATA_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              Clk_R,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [PKT_W-1:0]  Node_Packet,
  input  logic              Node_Packet_Push,
  output logic              Node_Full,
  output logic [CW-1:0]     Node_Count,
  output logic [7:0]        Drop_Count,
  output logic [PKT_W-1:0]  Packet_From_Node,
  output logic              Packet_From_Node_Valid,
  input  logic              Core_Load_Ack
);
  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic ack_q, pop, accept, reject;
`ifdef NODE_TXQ_SELF_FILTER_EN
  assign reject = Node_Packet[PKT_W-1 -: ADDR_W] == r_addr;
`else
  assign reject = &{1'b0, r_addr};
`endif
  assign Packet_From_Node_Valid = count != '0;
  assign Node_Full = count == CW'(DEPTH);
  assign Node_Count = count;
  assign Packet_From_Node = mem[rd_ptr];
  // an ack edge seen while empty is absorbed by ack_q and never pops later
  assign pop = Core_Load_Ack & ~ack_q & Packet_From_Node_Valid;
  assign accept = Node_Packet_Push & ~reject & (~Node_Full | pop);
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ack_q <= 1'b0;
      Drop_Count <= '0;
    end else begin
      ack_q <= Core_Load_Ack;
      if (accept) begin
        mem[wr_ptr] <= Node_Packet;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      if (Node_Packet_Push & ~accept & ~&Drop_Count) Drop_Count <= Drop_Count + 1'b1;
    end
  end
endmodule

// File: tb/tb_node_tx_queue.sv
// tb_node_tx_queue: directed test-plan steps plus random traffic checked against a queue-based model.
module tb_node_tx_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic [3:0] r_addr = 0;
  logic [28:0] pkt = 0;
  logic push = 0, ack = 0;
  logic full, valid;
  logic [2:0] cnt;
  logic [7:0] drop;
  logic [28:0] head;
  int n_pass = 0, n_chk = 0;
  logic [28:0] q[$];
  int drop_m = 0;
  bit ack_prev = 0;

  always #5 clk = ~clk;

  node_tx_queue dut (
    .Clk_R(clk), .Rst_n(rst_n), .r_addr(r_addr), .Node_Packet(pkt),
    .Node_Packet_Push(push), .Node_Full(full), .Node_Count(cnt), .Drop_Count(drop),
    .Packet_From_Node(head), .Packet_From_Node_Valid(valid), .Core_Load_Ack(ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all();
    chk("valid", {31'b0, valid}, {31'b0, q.size() != 0});
    chk("count", {29'b0, cnt}, q.size());
    chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("drop", {24'b0, drop}, drop_m);
    if (q.size() != 0) chk("head", {3'b0, head}, {3'b0, q[0]});
  endtask

  task automatic cyc();
    bit pop_m, acc, rej;
    pop_m = ack && !ack_prev && q.size() != 0;
`ifdef NODE_TXQ_SELF_FILTER_EN
    rej = pkt[28:25] == r_addr;
`else
    rej = 0;
`endif
    acc = push && !rej && (q.size() < DEPTH || pop_m);
    @(posedge clk);
    #1;
    if (pop_m) void'(q.pop_front());
    if (acc) q.push_back(pkt);
    if (push && !acc && drop_m < 255) drop_m++;
    ack_prev = ack;
    chk_all();
  endtask

  task automatic push1(input logic [28:0] p);
    pkt = p; push = 1; cyc(); push = 0;
  endtask

  task automatic pulse();
    ack = 1; cyc(); ack = 0; cyc();
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'b0, valid}, 0);
    chk("rst_full", {31'b0, full}, 0);
    chk("rst_count", {29'b0, cnt}, 0);
    chk("rst_drop", {24'b0, drop}, 0);
    chk("rst_head", {3'b0, head}, 0);
    rst_n = 1;
    cyc();
    push1(29'h200002A);
    chk("first_head", {3'b0, head}, 32'h200002A);
    chk("first_cnt", {29'b0, cnt}, 1);
    pulse();
    chk("first_empty", {31'b0, valid}, 0);
    push1(29'h200002A);
    push1(29'h2000064);
    ack = 1;
    repeat (10) cyc();
    chk("hold_head", {3'b0, head}, 32'h2000064);
    chk("hold_cnt", {29'b0, cnt}, 1);
    ack = 0; cyc();
    pulse();
    chk("hold_empty", {31'b0, valid}, 0);
    for (int i = 1; i <= 5; i++) push1({4'h1, 1'b0, 24'(i)});
    chk("fill_full", {31'b0, full}, 1);
    chk("fill_drop", {24'b0, drop}, 1);
    pkt = {4'h1, 1'b0, 24'd9}; push = 1; ack = 1; cyc(); push = 0; ack = 0; cyc();
    chk("swap_cnt", {29'b0, cnt}, 4);
    chk("swap_drop", {24'b0, drop}, 1);
    for (int i = 0; i < 4; i++) begin
      chk("order", {8'b0, head[23:0]}, i == 3 ? 9 : i + 2);
      pulse();
    end
    chk("drain_empty", {31'b0, valid}, 0);
    pkt = 29'h200002A; push = 1; ack = 1; cyc(); push = 0; ack = 0; cyc();
    chk("push_ack_empty", {29'b0, cnt}, 1);
    pulse();
    r_addr = 1;
    push1(29'h200002A);
`ifdef NODE_TXQ_SELF_FILTER_EN
    chk("self_valid", {31'b0, valid}, 0);
    chk("self_drop", {24'b0, drop}, 2);
`else
    chk("self_valid", {31'b0, valid}, 1);
    chk("self_drop", {24'b0, drop}, 1);
`endif
    r_addr = 0;
    push1(29'h4000011);
    push1(29'h6000022);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", {31'b0, valid}, 0);
    chk("mid_rst_count", {29'b0, cnt}, 0);
    chk("mid_rst_drop", {24'b0, drop}, 0);
    q.delete(); drop_m = 0; ack_prev = 0;
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    push1(29'h0ABCDEF);
    chk("post_rst_head", {3'b0, head}, 32'h0ABCDEF);
    r_addr = 3;
    for (int i = 0; i < 400; i++) begin
      pkt = 29'($urandom);
      push = 1'($urandom_range(0, 2) != 0);
      ack = 1'($urandom_range(0, 1));
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
